pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Two-entry pipeline register (main + skid) with a valid/ready handshake on
//   both sides. in_ready comes straight from a flop, so downstream back-pressure
//   never reaches upstream through combinational logic. The skid entry catches
//   the word that was already in flight when downstream stalled.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous kill of both stored entries
//   in_valid   upstream offers a word
//   in_ready   stage accepts a word this cycle (registered)
//   in_data    upstream payload, DATA_W bits
//   in_ctrl    upstream control bits, CTRL_W bits
//   out_valid  stage presents a word (occupancy != 0)
//   out_ready  downstream accepts the head word
//   out_data   head payload (main entry)
//   out_ctrl   head control bits, forced to zero when out_valid = 0
//   occupancy  number of stored entries, 0..2
//   halted     sticky: a word carrying the halt control bit has left the stage
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
`timescale 1ns/1ps
module pipe_skid_stage #(
  parameter int DATA_W              = 69,
  parameter int CTRL_W              = 5,
  parameter int HALT_BIT            = 4,
  parameter int CLEAR_DATA_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic              halted,
  output logic [15:0]       stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_fire;
  logic              out_fire;
  logic              halt_leaving;

  // Handshake decode. in_ready is a flop, so out_ready only ever reaches
  // in_ready through the next clock edge.
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;
  assign halt_leaving = out_fire & main_ctrl[HALT_BIT];

  // The head is always the main entry; control bits are masked on bubbles so
  // a stale entry can never assert a control line downstream.
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

  // Single state machine holding both entries, the registered in_ready, the
  // sticky halt flag and the stall counter. in_ready for the next cycle is
  // decided here from the next state and next halt value: it drops when the
  // stage becomes full or when a halt word leaves. Flush wins over any
  // same-cycle handshake, so neither an accepted word nor a departing halt
  // word takes effect on a flush cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      halted    <= 1'b0;
      in_ready  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end

      if (flush) begin
        state     <= EMPTY;
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA_ON_FLUSH != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
        in_ready  <= !halted;
      end else begin
        if (halt_leaving) begin
          halted <= 1'b1;
        end
        in_ready <= !(halted || halt_leaving);

        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
              state     <= ONE;
            end
          end
          ONE: begin
            if (in_fire && !out_fire) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
              state     <= TWO;
              in_ready  <= 1'b0;
            end else if (in_fire && out_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (out_fire) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
              state     <= ONE;
            end else begin
              in_ready <= 1'b0;
            end
          end
          default: begin
            state    <= EMPTY;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
